ex_stage_pipelined: RTL and testbench

Parametrised successor to the MIPS execute stage: computes the ALU result, branch target and writeback destination, and forwards the MEM/WB control bits into a valid/ready EX/MEM output register. It adds an iterative multiply/divide path that stalls upstream, downstream backpressure and a synchronous flush. It sits between the ID/EX register and the MEM stage.

---
 rtl/ex_pkg.sv | 27 ++
 rtl/ex_stage_pipelined_if.sv | 59 +++++
 rtl/ex_muldiv_iter.sv | 73 +++++++
 rtl/ex_stage_pipelined.sv | 170 +++++++++++++++++
 tb/tb_ex_stage_pipelined.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the pipelined execute stage: ALU operation codes,
// FSM state encoding and the multicycle-op classifier.
package ex_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_NOR  = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_MUL  = 4'd8;
    localparam logic [3:0] ALU_DIVU = 4'd9;
    localparam logic [3:0] ALU_REMU = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ex_state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/ex_stage_pipelined_if.sv
// Upstream (ID/EX) and downstream (EX/MEM) handshake bundle of the execute stage.
// The master side drives operands and out_ready; the slave side is the stage itself.
interface ex_stage_pipelined_if #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_RegDst;
    logic             in_RegWrite;
    logic             in_ALUSrc;
    logic             in_MemWrite;
    logic             in_MemRead;
    logic             in_MemToReg;
    logic             in_branch;
    logic [1:0]       in_load_mode;
    logic [3:0]       in_ALUOp;
    logic [REG_W-1:0] in_instr_bits_15_11;
    logic [REG_W-1:0] in_instr_bits_20_16;
    logic [XLEN-1:0]  in_extended_bits;
    logic [XLEN-1:0]  in_read_data1;
    logic [XLEN-1:0]  in_read_data2;
    logic [XLEN-1:0]  in_new_pc_value;

    logic             out_valid;
    logic             out_ready;
    logic             zero_out;
    logic             RegWrite_out;
    logic             MemWrite_out;
    logic             MemRead_out;
    logic             MemToReg_out;
    logic             branch_out;
    logic [1:0]       load_mode_out;
    logic [REG_W-1:0] writebackDestination_out;
    logic [XLEN-1:0]  aluResult_out;
    logic [XLEN-1:0]  rt_out;
    logic [XLEN-1:0]  pc_out;

    modport master (
        output flush, in_valid, in_RegDst, in_RegWrite, in_ALUSrc, in_MemWrite,
               in_MemRead, in_MemToReg, in_branch, in_load_mode, in_ALUOp,
               in_instr_bits_15_11, in_instr_bits_20_16, in_extended_bits,
               in_read_data1, in_read_data2, in_new_pc_value, out_ready,
        input  in_ready, out_valid, zero_out, RegWrite_out, MemWrite_out,
               MemRead_out, MemToReg_out, branch_out, load_mode_out,
               writebackDestination_out, aluResult_out, rt_out, pc_out
    );

    modport slave (
        input  flush, in_valid, in_RegDst, in_RegWrite, in_ALUSrc, in_MemWrite,
               in_MemRead, in_MemToReg, in_branch, in_load_mode, in_ALUOp,
               in_instr_bits_15_11, in_instr_bits_20_16, in_extended_bits,
               in_read_data1, in_read_data2, in_new_pc_value, out_ready,
        output in_ready, out_valid, zero_out, RegWrite_out, MemWrite_out,
               MemRead_out, MemToReg_out, branch_out, load_mode_out,
               writebackDestination_out, aluResult_out, rt_out, pc_out
    );
endinterface

// File: rtl/ex_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle over XLEN cycles.
// done marks the cycle of the final step; result is valid from the following cycle.
module ex_muldiv_iter
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    logic [3:0]      op_reg;
    logic [XLEN-1:0] acc_reg;   // product accumulator / partial remainder
    logic [XLEN-1:0] lo_reg;    // multiplier bits / dividend shifting into quotient
    logic [XLEN-1:0] opnd_reg;  // multiplicand (shifts left) / divisor (fixed)
    logic [CW-1:0]   cnt_reg;
    logic            busy_reg;

    logic [XLEN:0]   trial;
    logic [XLEN-1:0] diff;
    logic            take;

    // Divisor of zero always "takes", giving all-ones quotient and remainder == dividend.
    assign trial = {acc_reg, lo_reg[XLEN-1]};
    assign take  = trial >= {1'b0, opnd_reg};
    assign diff  = trial[XLEN-1:0] - opnd_reg;

    assign done   = busy_reg && (cnt_reg == CW'(XLEN - 1));
    assign result = (op_reg == ALU_DIVU) ? lo_reg : acc_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg   <= '0;
            acc_reg  <= '0;
            lo_reg   <= '0;
            opnd_reg <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (kill) begin
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            op_reg   <= op;
            acc_reg  <= '0;
            lo_reg   <= a;
            opnd_reg <= b;
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            cnt_reg <= cnt_reg + CW'(1);
            if (done) begin
                busy_reg <= 1'b0;
            end
            if (op_reg == ALU_MUL) begin
                acc_reg  <= acc_reg + (lo_reg[0] ? opnd_reg : '0);
                lo_reg   <= lo_reg >> 1;
                opnd_reg <= opnd_reg << 1;
            end else begin
                acc_reg <= take ? diff : trial[XLEN-1:0];
                lo_reg  <= {lo_reg[XLEN-2:0], take};
            end
        end
    end

endmodule

// File: rtl/ex_stage_pipelined.sv
// Execute stage with a valid/ready EX/MEM output register: single-cycle ALU, branch
// adder and RegDst mux, plus an iterative mul/div path that stalls the upstream.
module ex_stage_pipelined
    import ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    ex_stage_pipelined_if.slave bus
);
    ex_state_t state_reg, state_next;

    logic            slot_free, in_ready_c, accept;
    logic            load_single, load_multi, load_any, start_md, md_done;
    logic [XLEN-1:0] op_a, op_b, alu_result, branch_target, md_result;
    logic [REG_W-1:0] wb_dest;
    logic [6:0]      in_ctl;

    logic [XLEN-1:0]  hold_pc_reg, hold_rt_reg;
    logic [REG_W-1:0] hold_wb_reg;
    logic [6:0]       hold_ctl_reg;

    logic             out_valid_reg, zero_reg;
    logic [6:0]       out_ctl_reg;
    logic [REG_W-1:0] out_wb_reg;
    logic [XLEN-1:0]  out_result_reg, out_rt_reg, out_pc_reg;

    logic [XLEN-1:0]  ld_result, ld_pc, ld_rt;
    logic [REG_W-1:0] ld_wb;
    logic [6:0]       ld_ctl;

    assign op_a          = bus.in_read_data1;
    assign op_b          = bus.in_ALUSrc ? bus.in_extended_bits : bus.in_read_data2;
    assign branch_target = bus.in_new_pc_value + (bus.in_extended_bits << 2);
    assign wb_dest       = bus.in_RegDst ? bus.in_instr_bits_15_11 : bus.in_instr_bits_20_16;
    assign in_ctl        = {bus.in_RegWrite, bus.in_MemWrite, bus.in_MemRead,
                            bus.in_MemToReg, bus.in_branch, bus.in_load_mode};

    always_comb begin
        alu_result = '0;
        case (bus.in_ALUOp)
            ALU_AND:  alu_result = op_a & op_b;
            ALU_OR:   alu_result = op_a | op_b;
            ALU_ADD:  alu_result = op_a + op_b;
            ALU_SUB:  alu_result = op_a - op_b;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_NOR:  alu_result = ~(op_a | op_b);
            ALU_XOR:  alu_result = op_a ^ op_b;
            default:  alu_result = '0;
        endcase
    end

    ex_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (start_md),
        .kill   (bus.flush),
        .op     (bus.in_ALUOp),
        .a      (op_a),
        .b      (op_b),
        .done   (md_done),
        .result (md_result)
    );

    assign slot_free = !out_valid_reg || bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (start_md)   state_next = BUSY;
                BUSY:    if (md_done)    state_next = DONE;
                DONE:    if (load_multi) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // A flush in the same cycle suppresses both accept and the DONE load.
    always_comb begin
        in_ready_c  = 1'b0;
        accept      = 1'b0;
        load_single = 1'b0;
        load_multi  = 1'b0;
        start_md    = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_c  = slot_free;
                accept      = bus.in_valid && slot_free && !bus.flush;
                load_single = accept && !is_multicycle(bus.in_ALUOp);
                start_md    = accept && is_multicycle(bus.in_ALUOp);
            end
            DONE:    load_multi = slot_free && !bus.flush;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_pc_reg  <= '0;
            hold_rt_reg  <= '0;
            hold_wb_reg  <= '0;
            hold_ctl_reg <= '0;
        end else if (start_md) begin
            hold_pc_reg  <= branch_target;
            hold_rt_reg  <= bus.in_read_data2;
            hold_wb_reg  <= wb_dest;
            hold_ctl_reg <= in_ctl;
        end
    end

    assign load_any  = load_single || load_multi;
    assign ld_result = load_multi ? md_result    : alu_result;
    assign ld_pc     = load_multi ? hold_pc_reg  : branch_target;
    assign ld_rt     = load_multi ? hold_rt_reg  : bus.in_read_data2;
    assign ld_wb     = load_multi ? hold_wb_reg  : wb_dest;
    assign ld_ctl    = load_multi ? hold_ctl_reg : in_ctl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            zero_reg       <= 1'b0;
            out_ctl_reg    <= '0;
            out_wb_reg     <= '0;
            out_result_reg <= '0;
            out_rt_reg     <= '0;
            out_pc_reg     <= '0;
        end else if (bus.flush) begin
            out_valid_reg <= 1'b0;
        end else if (load_any) begin
            out_valid_reg  <= 1'b1;
            zero_reg       <= (ld_result == '0);
            out_ctl_reg    <= ld_ctl;
            out_wb_reg     <= ld_wb;
            out_result_reg <= ld_result;
            out_rt_reg     <= ld_rt;
            out_pc_reg     <= ld_pc;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.in_ready                 = in_ready_c;
    assign bus.out_valid                = out_valid_reg;
    assign bus.zero_out                 = zero_reg;
    assign bus.RegWrite_out             = out_ctl_reg[6];
    assign bus.MemWrite_out             = out_ctl_reg[5];
    assign bus.MemRead_out              = out_ctl_reg[4];
    assign bus.MemToReg_out             = out_ctl_reg[3];
    assign bus.branch_out               = out_ctl_reg[2];
    assign bus.load_mode_out            = out_ctl_reg[1:0];
    assign bus.writebackDestination_out = out_wb_reg;
    assign bus.aluResult_out            = out_result_reg;
    assign bus.rt_out                   = out_rt_reg;
    assign bus.pc_out                   = out_pc_reg;

endmodule

// File: tb/tb_ex_stage_pipelined.sv
// Directed bench for ex_stage_pipelined: ALU ops, mul/div latency, backpressure,
// flush and asynchronous reset, with hand-computed expected values.
module tb_ex_stage_pipelined;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ex_stage_pipelined_if #(.XLEN(32), .REG_W(5)) bus ();

    ex_stage_pipelined #(.XLEN(32), .REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%0h expected=%0h", n_vec, tag, obs, exp);
    endtask

    task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ext, input logic alusrc, input logic [31:0] pc);
        bus.in_ALUOp         = op;
        bus.in_read_data1    = a;
        bus.in_read_data2    = b;
        bus.in_extended_bits = ext;
        bus.in_ALUSrc        = alusrc;
        bus.in_new_pc_value  = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One single-cycle op with out_ready=1; result checked after the accepting edge.
    task automatic alu1(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        set_in(op, a, b, 32'd0, 1'b0, 32'd0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check(tag, 64'(bus.aluResult_out), 64'(exp));
    endtask

    // Issue a mul/div op, count edges until out_valid, track in_ready staying low.
    task automatic run_multi(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int edges, output logic ready_low);
        set_in(op, a, b, 32'd0, 1'b0, 32'd0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        edges = 0;
        ready_low = !bus.in_ready;
        while (edges < 100) begin
            step();
            edges++;
            if (bus.out_valid) break;
            ready_low &= !bus.in_ready;
        end
    endtask

    int   edges;
    logic ready_low;
    logic seen_valid;

    initial begin
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_RegDst = 1'b0;
        bus.in_RegWrite = 1'b0;
        bus.in_MemWrite = 1'b0;
        bus.in_MemRead = 1'b0;
        bus.in_MemToReg = 1'b0;
        bus.in_branch = 1'b0;
        bus.in_load_mode = 2'd0;
        bus.in_instr_bits_15_11 = 5'd0;
        bus.in_instr_bits_20_16 = 5'd0;
        set_in(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);

        #2;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_result", 64'(bus.aluResult_out), 64'd0);
        step();
        reset = 1'b0;

        // ADD with immediate; writeback goes to rt field.
        set_in(4'd2, 32'd7, 32'd0, 32'd32, 1'b1, 32'd0);
        bus.in_instr_bits_20_16 = 5'd9;
        bus.in_instr_bits_15_11 = 5'd3;
        bus.in_RegWrite = 1'b1;
        bus.in_load_mode = 2'd2;
        bus.in_valid = 1'b1;
        step();
        check("add_valid", 64'(bus.out_valid), 64'd1);
        check("add_result", 64'(bus.aluResult_out), 64'd39);
        check("add_pc", 64'(bus.pc_out), 64'd128);
        check("add_zero", 64'(bus.zero_out), 64'd0);
        check("add_wb", 64'(bus.writebackDestination_out), 64'd9);
        check("add_ctl", 64'({bus.RegWrite_out, bus.load_mode_out}), 64'b110);

        // SUB back-to-back (accept and drain on the same edge).
        set_in(4'd3, 32'd5, 32'd5, 32'd0, 1'b0, 32'h100);
        bus.in_RegDst = 1'b1;
        bus.in_instr_bits_15_11 = 5'd5;
        bus.in_branch = 1'b1;
        bus.in_RegWrite = 1'b0;
        bus.in_load_mode = 2'd0;
        step();
        bus.in_valid = 1'b0;
        check("sub_result", 64'(bus.aluResult_out), 64'd0);
        check("sub_zero", 64'(bus.zero_out), 64'd1);
        check("sub_branch", 64'(bus.branch_out), 64'd1);
        check("sub_wb", 64'(bus.writebackDestination_out), 64'd5);
        check("sub_rt", 64'(bus.rt_out), 64'd5);
        check("sub_pc", 64'(bus.pc_out), 64'h100);
        bus.in_branch = 1'b0;
        bus.in_RegDst = 1'b0;
        step();
        check("drain_valid", 64'(bus.out_valid), 64'd0);

        alu1("and", 4'd0, 32'hF0F0, 32'hFF00, 32'hF000);
        alu1("or", 4'd1, 32'hF0F0, 32'h0F00, 32'hFFF0);
        alu1("slt", 4'd4, 32'hFFFFFFFF, 32'd1, 32'd1);
        alu1("sltu", 4'd5, 32'hFFFFFFFF, 32'd1, 32'd0);
        alu1("nor", 4'd6, 32'd0, 32'h0000FFFF, 32'hFFFF0000);
        alu1("xor", 4'd7, 32'hF0, 32'hFF, 32'h0F);
        alu1("op12", 4'd12, 32'd5, 32'd3, 32'd0);
        check("op12_zero", 64'(bus.zero_out), 64'd1);

        run_multi(4'd8, 32'd6, 32'd7, edges, ready_low);
        check("mul_latency", 64'(edges), 64'd33);
        check("mul_stall", 64'(ready_low), 64'd1);
        check("mul_result", 64'(bus.aluResult_out), 64'd42);
        check("mul_ready_back", 64'(bus.in_ready), 64'd1);
        run_multi(4'd8, 32'hFFFFFFFF, 32'd2, edges, ready_low);
        check("mul_wrap", 64'(bus.aluResult_out), 64'hFFFFFFFE);
        run_multi(4'd9, 32'd100, 32'd7, edges, ready_low);
        check("divu_latency", 64'(edges), 64'd33);
        check("divu", 64'(bus.aluResult_out), 64'd14);
        run_multi(4'd10, 32'd100, 32'd7, edges, ready_low);
        check("remu", 64'(bus.aluResult_out), 64'd2);
        run_multi(4'd9, 32'd9, 32'd0, edges, ready_low);
        check("divu_by0", 64'(bus.aluResult_out), 64'hFFFFFFFF);
        run_multi(4'd10, 32'd9, 32'd0, edges, ready_low);
        check("remu_by0", 64'(bus.aluResult_out), 64'd9);
        step();

        // Backpressure: hold one result while a second op waits.
        set_in(4'd2, 32'd1, 32'd0, 32'd1, 1'b1, 32'd0);
        bus.in_valid = 1'b1;
        step();
        set_in(4'd2, 32'd2, 32'd0, 32'd2, 1'b1, 32'd0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_hold", 64'({bus.out_valid, bus.in_ready, bus.aluResult_out}),
                  {30'd0, 1'b1, 1'b0, 32'd2});
            check("bp_pc", 64'(bus.pc_out), 64'd4);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("bp_release", 64'({bus.out_valid, bus.aluResult_out}), {31'd0, 1'b1, 32'd4});
        step();

        // Flush in BUSY cycle 10 kills the divide.
        set_in(4'd9, 32'd100, 32'd7, 32'd0, 1'b0, 32'd0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_ready", 64'(bus.in_ready), 64'd1);
        seen_valid = 1'b0;
        repeat (40) begin
            step();
            seen_valid |= bus.out_valid;
        end
        check("flush_no_result", 64'(seen_valid), 64'd0);

        // Flush and accept in the same cycle: flush wins.
        set_in(4'd2, 32'd3, 32'd0, 32'd3, 1'b1, 32'd0);
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_accept", 64'(bus.out_valid), 64'd0);

        // Flush clears a stalled output register.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        check("flush_out", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset in the middle of a multiply.
        set_in(4'd2, 32'h55, 32'h77, 32'h10, 1'b1, 32'd4);
        bus.in_valid = 1'b1;
        step();
        check("pre_reset", 64'(bus.aluResult_out), 64'h65);
        set_in(4'd8, 32'd3, 32'd5, 32'd0, 1'b0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();
        #2;
        reset = 1'b1;
        #1;
        check("rst_result", 64'(bus.aluResult_out), 64'd0);
        check("rst_pc", 64'(bus.pc_out), 64'd0);
        check("rst_rt", 64'(bus.rt_out), 64'd0);
        check("rst_valid_ready", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        step();
        reset = 1'b0;
        alu1("post_reset_add", 4'd2, 32'd1, 32'd1, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
